// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core's memory
// stage and one external req/gnt master. The core has priority by default.
// A starvation counter forces an external grant after STARVE_MAX denied cycles.
// A read locks the port until its data returns RD_LAT cycles after issue.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              Rst,
  // core memory stage
  input  logic [3:0]        core_en,
  input  logic              core_wea,
  input  logic              core_rea,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_din,
  output logic [DATA_W-1:0] core_dout,
  output logic              mem_hold,
  // external master
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [3:0]        ext_be,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  // RAM port
  output logic [3:0]        ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  // owner flag encoding for an in-flight read
  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_EXT  = 1'b1;

  localparam logic [1:0] LAT_INIT   = 2'(RD_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_reg, state_next;
  logic [1:0]        lat_cnt_reg, lat_cnt_next;
  logic              owner_reg, owner_next;
  logic [3:0]        starve_cnt_reg, starve_cnt_next;
  logic [DATA_W-1:0] core_hold_reg, core_hold_next;
  logic [DATA_W-1:0] ext_rdata_reg, ext_rdata_next;
  logic              ext_rvalid_reg, ext_rvalid_next;

  logic core_req;
  logic grant_core;
  logic grant_ext;
  logic data_valid;
  logic core_valid;
  logic ext_valid;

  // A core request needs at least one byte lane and an operation; a
  // simultaneous read+write is treated as a write.
  assign core_req   = (core_en != 4'd0) && (core_wea || core_rea);

  // The last wait cycle is the one in which ram_dout carries the read data.
  assign data_valid = (state_reg == ST_RD_WAIT) && (lat_cnt_reg == 2'd1);
  assign core_valid = data_valid && (owner_reg == OWN_CORE);
  assign ext_valid  = data_valid && (owner_reg == OWN_EXT);

  // State, latency counter, read owner, starvation count and data holders.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_reg      <= ST_IDLE;
      lat_cnt_reg    <= 2'd0;
      owner_reg      <= OWN_CORE;
      starve_cnt_reg <= 4'd0;
      core_hold_reg  <= '0;
      ext_rdata_reg  <= '0;
      ext_rvalid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lat_cnt_reg    <= lat_cnt_next;
      owner_reg      <= owner_next;
      starve_cnt_reg <= starve_cnt_next;
      core_hold_reg  <= core_hold_next;
      ext_rdata_reg  <= ext_rdata_next;
      ext_rvalid_reg <= ext_rvalid_next;
    end
  end

  // Arbitration, RAM port drive, stall generation and next-state selection.
  always_comb begin
    state_next   = state_reg;
    lat_cnt_next = lat_cnt_reg;
    owner_next   = owner_reg;
    grant_core   = 1'b0;
    grant_ext    = 1'b0;
    ram_en       = 4'd0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_din      = '0;
    mem_hold     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // The external master wins when alone or once it has starved long enough.
        if (ext_req && (!core_req || (starve_cnt_reg == STARVE_LIM))) begin
          grant_ext = 1'b1;
        end else if (core_req) begin
          grant_core = 1'b1;
        end

        if (grant_ext) begin
          ram_en   = ext_be;
          ram_we   = ext_we;
          ram_addr = ext_addr;
          ram_din  = ext_wdata;
          if (!ext_we) begin
            state_next   = ST_RD_WAIT;
            lat_cnt_next = LAT_INIT;
            owner_next   = OWN_EXT;
          end
        end else if (grant_core) begin
          ram_en   = core_en;
          ram_we   = core_wea;
          ram_addr = core_addr;
          ram_din  = core_din;
          if (!core_wea) begin
            state_next   = ST_RD_WAIT;
            lat_cnt_next = LAT_INIT;
            owner_next   = OWN_CORE;
          end
        end

        // Only a granted core write lets the pipeline advance this cycle.
        mem_hold = core_req && !(grant_core && core_wea);
      end

      ST_RD_WAIT: begin
        if (lat_cnt_reg == 2'd1) begin
          state_next = ST_IDLE;
        end else begin
          lat_cnt_next = lat_cnt_reg - 2'd1;
        end

        // A core read releases the pipeline in its data cycle; during an
        // external read any core request must wait.
        if (owner_reg == OWN_CORE) begin
          mem_hold = !data_valid;
        end else begin
          mem_hold = core_req;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Next values for the starvation counter and the read-data holders.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    core_hold_next  = core_hold_reg;
    ext_rdata_next  = ext_rdata_reg;
    ext_rvalid_next = ext_valid;

    if (grant_ext) begin
      starve_cnt_next = 4'd0;
    end else if (ext_req && (starve_cnt_reg < STARVE_LIM)) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end

    if (core_valid) begin
      core_hold_next = ram_dout;
    end

    if (ext_valid) begin
      ext_rdata_next = ram_dout;
    end
  end

  // Core read data bypasses the hold register in its data cycle.
  assign core_dout  = core_valid ? ram_dout : core_hold_reg;
  assign ext_gnt    = grant_ext;
  assign ext_rvalid = ext_rvalid_reg;
  assign ext_rdata  = ext_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus for dmem_arbiter with RD_LAT=2 and
// STARVE_MAX=4. It contains a behavioural RAM and a cycle-time model that
// predicts every output each cycle from the arbitration rules. Literal checks
// at key points pin the model.
module tb_dmem_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        Rst;
  logic [3:0]  core_en;
  logic        core_wea;
  logic        core_rea;
  logic [31:0] core_addr;
  logic [31:0] core_din;
  logic [31:0] core_dout;
  logic        mem_hold;
  logic        ext_req;
  logic        ext_we;
  logic [3:0]  ext_be;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;
  logic [3:0]  ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .RD_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .Rst(Rst),
    .core_en(core_en), .core_wea(core_wea), .core_rea(core_rea),
    .core_addr(core_addr), .core_din(core_din), .core_dout(core_dout),
    .mem_hold(mem_hold),
    .ext_req(ext_req), .ext_we(ext_we), .ext_be(ext_be),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- behavioural RAM (read data LAT cycles after issue) ----
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] rd_pipe [LAT];
  assign ram_dout = rd_pipe[LAT-1];

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : 32'h0;
  endfunction

  initial begin
    for (int i = 0; i < LAT; i++) rd_pipe[i] = 32'h0;
    forever begin
      @(posedge clk);
      if (ram_en != 4'd0) begin
        if (ram_we) ram_mem[ram_addr] = merge(ram_word(ram_addr), ram_en, ram_din);
        else        rd_pipe[0] <= ram_word(ram_addr);
      end
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  // ---------------- reference model: cycle-time bookkeeping ---------------
  logic [31:0] mdl_mem [logic [31:0]];

  function automatic logic [31:0] mdl_word(input logic [31:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : 32'h0;
  endfunction

  initial begin : model
    int          cyc, free_at, ret_cyc, rv_cyc, starve;
    bit          own_core, creq, is_free, ext_wins, core_wins;
    logic [31:0] ret_data, ext_ret_data, hold_m, rdata_m;
    logic        e_gnt, e_we, e_hold, e_rvalid, issued;
    logic [3:0]  e_en;
    logic [31:0] e_addr, e_din, e_cdout;
    cyc = 0; free_at = 0; ret_cyc = -1; rv_cyc = -1; starve = 0; own_core = 1'b0;
    ret_data = 0; ext_ret_data = 0; hold_m = 0; rdata_m = 0;
    forever begin
      @(negedge clk);
      if (Rst !== 1'b1) begin
        free_at = cyc; ret_cyc = -1; rv_cyc = -1; starve = 0;
        hold_m = 32'h0; rdata_m = 32'h0;
        chk1 ("rst_gnt",    ext_gnt,    1'b0);
        chk1 ("rst_rvalid", ext_rvalid, 1'b0);
        chk1 ("rst_we",     ram_we,     1'b0);
        chk32("rst_en",     32'(ram_en), 32'h0);
        chk32("rst_cdout",  core_dout,  32'h0);
        chk32("rst_rdata",  ext_rdata,  32'h0);
      end else begin
        creq    = (core_en != 4'd0) && (core_wea || core_rea);
        is_free = (cyc >= free_at);
        e_gnt = 1'b0; e_we = 1'b0; e_hold = 1'b0; e_en = 4'd0; issued = 1'b0;
        e_addr = 32'h0; e_din = 32'h0; e_cdout = hold_m;
        if (cyc == rv_cyc) rdata_m = ext_ret_data;
        e_rvalid = (cyc == rv_cyc);
        if (is_free) begin
          ext_wins  = ext_req && (!creq || starve == SMAX);
          core_wins = creq && !ext_wins;
          if (ext_wins) begin
            e_gnt = 1'b1; issued = 1'b1;
            e_en = ext_be; e_we = ext_we; e_addr = ext_addr; e_din = ext_wdata;
            if (ext_we) mdl_mem[ext_addr] = merge(mdl_word(ext_addr), ext_be, ext_wdata);
            else begin
              free_at = cyc + LAT + 1; rv_cyc = cyc + LAT + 1;
              ext_ret_data = mdl_word(ext_addr); own_core = 1'b0;
            end
          end else if (core_wins) begin
            issued = 1'b1;
            e_en = core_en; e_we = core_wea; e_addr = core_addr; e_din = core_din;
            if (core_wea) mdl_mem[core_addr] = merge(mdl_word(core_addr), core_en, core_din);
            else begin
              free_at = cyc + LAT + 1; ret_cyc = cyc + LAT;
              ret_data = mdl_word(core_addr); own_core = 1'b1;
            end
          end
          e_hold = creq && !(core_wins && core_wea);
        end else if (own_core) begin
          e_hold = (cyc != ret_cyc);
          if (cyc == ret_cyc) e_cdout = ret_data;
        end else begin
          e_hold = creq;
        end
        chk1 ("mdl_gnt",    ext_gnt,     e_gnt);
        chk1 ("mdl_we",     ram_we,      e_we);
        chk32("mdl_en",     32'(ram_en), 32'(e_en));
        chk1 ("mdl_hold",   mem_hold,    e_hold);
        chk32("mdl_cdout",  core_dout,   e_cdout);
        chk1 ("mdl_rvalid", ext_rvalid,  e_rvalid);
        chk32("mdl_rdata",  ext_rdata,   rdata_m);
        if (issued) begin
          chk32("mdl_addr", ram_addr, e_addr);
          chk32("mdl_din",  ram_din,  e_din);
        end
        if (!is_free && own_core && cyc == ret_cyc) hold_m = ret_data;
        if (e_gnt) starve = 0;
        else if (ext_req && starve < SMAX) starve++;
      end
      cyc++;
    end
  end

  // ---------------- directed stimulus -------------------------------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic [3:0] en, input logic we, input logic re,
                          input logic [31:0] a, input logic [31:0] d);
    core_en = en; core_wea = we; core_rea = re; core_addr = a; core_din = d;
  endtask

  task automatic set_ext(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d);
    ext_req = req; ext_we = we; ext_be = be; ext_addr = a; ext_wdata = d;
  endtask

  initial begin
    logic [31:0] ca, cd;
    Rst = 1'b1;
    set_core(4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_ext(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #2 Rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk1 ("lit_rst_hold",  mem_hold,  1'b0);
      chk32("lit_rst_cdout", core_dout, 32'h0);
      nxt();
    end
    Rst = 1'b1;

    // core write
    set_core(4'hF, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    chk1 ("lit_cwr_we",   ram_we,      1'b1);
    chk32("lit_cwr_en",   32'(ram_en), 32'hF);
    chk32("lit_cwr_addr", ram_addr,    32'h100);
    chk1 ("lit_cwr_hold", mem_hold,    1'b0);
    nxt();

    // core read: hold for LAT cycles, data in the next
    set_core(4'hF, 1'b0, 1'b1, 32'h100, 32'h0);
    @(negedge clk); chk1("lit_crd_c0_hold", mem_hold, 1'b1); nxt();
    @(negedge clk); chk1("lit_crd_c1_hold", mem_hold, 1'b1); nxt();
    @(negedge clk);
    chk1 ("lit_crd_c2_hold", mem_hold,  1'b0);
    chk32("lit_crd_c2_dout", core_dout, 32'hDEADBEEF);
    nxt();
    set_core(4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); chk32("lit_crd_after", core_dout, 32'hDEADBEEF); nxt();

    // back-to-back core writes starve a pending external write
    for (int k = 0; k < 6; k++) begin
      ca = (k < 4) ? 32'h300 + 32'(4 * k) : 32'h310;
      cd = 32'hC0DE0000 + 32'((k < 4) ? k : 4);
      set_core(4'hF, 1'b1, 1'b0, ca, cd);
      set_ext(k < 5, 1'b1, 4'hF, 32'h200, 32'h12345678);
      @(negedge clk);
      chk1 ("lit_stv_gnt",  ext_gnt,  k == 4);
      chk1 ("lit_stv_hold", mem_hold, k == 4);
      chk32("lit_stv_addr", ram_addr, (k == 4) ? 32'h200 : ca);
      nxt();
    end
    set_core(4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_ext(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    nxt();

    // external read with a core write stalled behind it
    set_ext(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
    @(negedge clk); chk1("lit_erd_gnt", ext_gnt, 1'b1); nxt();
    set_ext(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_core(4'hF, 1'b1, 1'b0, 32'h400, 32'h11);
    @(negedge clk);
    chk1 ("lit_erd_c1_hold", mem_hold,    1'b1);
    chk32("lit_erd_c1_en",   32'(ram_en), 32'h0);
    nxt();
    @(negedge clk); chk1("lit_erd_c2_hold", mem_hold, 1'b1); nxt();
    @(negedge clk);
    chk1 ("lit_erd_c3_hold",   mem_hold,   1'b0);
    chk1 ("lit_erd_c3_rvalid", ext_rvalid, 1'b1);
    chk32("lit_erd_c3_rdata",  ext_rdata,  32'h12345678);
    nxt();
    set_core(4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk1 ("lit_erd_c4_rvalid", ext_rvalid, 1'b0);
    chk32("lit_erd_c4_rdata",  ext_rdata,  32'h12345678);
    nxt();

    // reset during an external read wait
    set_ext(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    @(negedge clk); chk1("lit_rrd_gnt", ext_gnt, 1'b1); nxt();
    set_ext(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1 Rst = 1'b0;
    #1;
    chk32("lit_arst_rdata",  ext_rdata,   32'h0);
    chk32("lit_arst_cdout",  core_dout,   32'h0);
    chk1 ("lit_arst_rvalid", ext_rvalid,  1'b0);
    chk1 ("lit_arst_hold",   mem_hold,    1'b0);
    chk32("lit_arst_en",     32'(ram_en), 32'h0);
    nxt();
    nxt();
    Rst = 1'b1;
    repeat (4) begin
      @(negedge clk); chk1("lit_arst_no_rvalid", ext_rvalid, 1'b0); nxt();
    end

    // byte enables zero: no request
    set_core(4'h0, 1'b1, 1'b0, 32'h600, 32'h77);
    @(negedge clk);
    chk32("lit_noen_en",   32'(ram_en), 32'h0);
    chk1 ("lit_noen_we",   ram_we,      1'b0);
    chk1 ("lit_noen_hold", mem_hold,    1'b0);
    nxt();

    // read+write treated as write, partial byte enables
    set_core(4'h3, 1'b1, 1'b1, 32'h500, 32'hCAFEF00D);
    @(negedge clk);
    chk1 ("lit_rw_we",   ram_we,      1'b1);
    chk32("lit_rw_en",   32'(ram_en), 32'h3);
    chk1 ("lit_rw_hold", mem_hold,    1'b0);
    nxt();

    // core read conflicting with an external read: core first
    set_core(4'hF, 1'b0, 1'b1, 32'h500, 32'h0);
    set_ext(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    @(negedge clk);
    chk1("lit_cf_c0_gnt",  ext_gnt,  1'b0);
    chk1("lit_cf_c0_hold", mem_hold, 1'b1);
    nxt();
    @(negedge clk); chk1("lit_cf_c1_gnt", ext_gnt, 1'b0); nxt();
    @(negedge clk);
    chk1 ("lit_cf_c2_hold",  mem_hold,  1'b0);
    chk32("lit_cf_c2_cdout", core_dout, 32'h0000F00D);
    chk1 ("lit_cf_c2_gnt",   ext_gnt,   1'b0);
    nxt();
    set_core(4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); chk1("lit_cf_c3_gnt", ext_gnt, 1'b1); nxt();
    set_ext(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk); nxt();
    @(negedge clk); nxt();
    @(negedge clk);
    chk1 ("lit_cf_c6_rvalid", ext_rvalid, 1'b1);
    chk32("lit_cf_c6_rdata",  ext_rdata,  32'hDEADBEEF);
    nxt();
    repeat (2) nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter and sequencer for the single-port data memory behind the Mini-RISC-V core. It shares the memory between the core's memory stage (`mem_*` port) and one external requester (UART/debug/DMA-style master) using a req/gnt handshake. It generates `mem_hold`, which stalls the core pipeline while the core is blocked or waiting for read data. By default the core has priority; a starvation counter guarantees the external master a grant.

## Interface
Parameters:
- `ADDR_W`, 32, address width of both masters and the RAM port
- `DATA_W`, 32, data width
- `RD_LAT`, 1, RAM read latency in cycles (1..3); `ram_dout` is valid `RD_LAT` cycles after the issue cycle
- `STARVE_MAX`, 4, number of denied external-request cycles after which the external master wins the next conflict (1..15)

Ports. The block runs on one clock. Reset is asynchronous and active-low.
- `clk` in 1: system clock, rising edge
- `Rst` in 1: asynchronous, active-low reset
- `core_en` in 4: core byte enables; a core request exists only if `core_en != 0`
- `core_wea` in 1: core write
- `core_rea` in 1: core read
- `core_addr` in ADDR_W: core address
- `core_din` in DATA_W: core write data
- `core_dout` out DATA_W: core read data
- `mem_hold` out 1: stall to the core pipeline
- `ext_req` in 1: external request; held stable with its fields until `ext_gnt`
- `ext_we` in 1: external write (0 = read)
- `ext_be` in 4: external byte enables
- `ext_addr` in ADDR_W: external address
- `ext_wdata` in DATA_W: external write data
- `ext_gnt` out 1: one-cycle pulse in the external request's issue cycle
- `ext_rvalid` out 1: one-cycle pulse when `ext_rdata` is newly valid
- `ext_rdata` out DATA_W: external read data, held until the next external read returns
- `ram_en` out 4, `ram_we` out 1, `ram_addr` out ADDR_W, `ram_din` out DATA_W: RAM port
- `ram_dout` in DATA_W: RAM read data

## Operation
- A core request is `core_en != 0 && (core_wea || core_rea)`. If `core_wea` and `core_rea` are both set, the request is treated as a write.
- The FSM has two states.
  - IDLE: issue is decided combinationally each cycle.
  - RD_WAIT: a read is in flight. A counter runs from `RD_LAT` down to 1, and an owner flag (CORE/EXT) records who issued the read.
- Issue in IDLE:
  - If only one master requests, that master is granted.
  - If both request, the core wins unless `starve_cnt == STARVE_MAX`, in which case the external master wins.
  - The granted master's fields drive `ram_*` in the same cycle. With no grant, `ram_en = 0` and `ram_we = 0`.
- Writes complete in the issue cycle and the FSM stays in IDLE.
- Reads move the FSM to RD_WAIT. No new issue happens in RD_WAIT.
- In the last RD_WAIT cycle (`ram_dout` valid), the FSM returns to IDLE:
  - CORE owner: `core_dout = ram_dout` combinationally and it is latched into the hold register.
  - EXT owner: `ext_rdata` is registered from `ram_dout` and `ext_rvalid` pulses on the next cycle.
- `core_dout` equals `ram_dout` in a core-valid cycle; otherwise it equals the hold register.
- `mem_hold = 1` whenever either of these holds:
  - a core request is present in IDLE and not granted, or a core read is being issued;
  - the FSM is in RD_WAIT with owner CORE, except in the data-valid cycle.
- In RD_WAIT with owner EXT, a core request also raises `mem_hold`.
- The core pipeline keeps its request fields stable while `mem_hold = 1`. The arbiter ignores core inputs in the core-valid cycle (RD_WAIT).
- `starve_cnt` is 4 bits. It increments, saturating at STARVE_MAX, on every cycle with `ext_req = 1 && ext_gnt = 0`. It clears to 0 on `ext_gnt`.

## Timing
- Reset values: FSM in IDLE, `starve_cnt = 0`, hold register 0, `ext_rdata = 0`, `ext_rvalid = 0`. Combinational outputs therefore evaluate to `ext_gnt = 0`, `ram_en = 0`, `ram_we = 0`, `mem_hold = 0` (with no request pending), and `core_dout = 0`.
- Core write: 0 cycles of hold when granted.
- Core read: `mem_hold` is high for `RD_LAT` cycles (issue cycle through the cycle before valid), then low in the valid cycle.
- External write: `ext_gnt` pulses in the issue cycle.
- External read: `ext_rvalid` pulses `RD_LAT + 1` cycles after `ext_gnt`.
- A request issued in an RD_WAIT data-valid cycle is not possible. The earliest next issue is the following cycle.
- Reset asserted mid-read: the FSM goes to IDLE immediately. The in-flight read is discarded and no `ext_rvalid` pulse follows. `core_dout` reads 0 and `ext_rdata` is cleared.
- When `starve_cnt == STARVE_MAX` and only the core requests, the core is granted and the count stays saturated.

## Test plan
- Core write, `core_en = F`, `core_wea = 1`, addr `0x100`, din `0xDEADBEEF` → same cycle `ram_we = 1`, `ram_en = F`, `ram_addr = 0x100`, `mem_hold = 0`.
- Core read of `0x100` holding `0xDEADBEEF`, `RD_LAT = 1` → cycle 0: `mem_hold = 1`. Cycle 1: `mem_hold = 0`, `core_dout = 0xDEADBEEF`. `core_dout` stays `0xDEADBEEF` afterwards.
- Back-to-back core writes with `ext_req` held as an external write → core is granted in cycles 0–3 (`starve_cnt` 0..3). Cycle 4: `ext_gnt = 1`, `mem_hold = 1`, `ram_addr = ext_addr`. Cycle 5: core is granted and `starve_cnt = 0`.
- External read of `0x200` holding `0x12345678`, `RD_LAT = 2` → `ext_gnt` in cycle 0, `ext_rvalid` pulse in cycle 3 with `ext_rdata = 0x12345678`. A core request in cycles 1–2 sees `mem_hold = 1`.
- `Rst` driven low in RD_WAIT of an external read → all outputs return to reset values asynchronously. No `ext_rvalid` pulse occurs after release.
- `core_en = 0` with `core_wea = 1` → `ram_en = 0`, `ram_we = 0`, `mem_hold = 0`.
